ram_arb_ctrl: RTL and testbench
===============================

RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, RAM data width.
REQ-002 SHALL have parameter DEPTH_LOG, default 2, RAM address width (4 words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports {a,b}_req  input  1  client transaction valid; held until accepted.
REQ-006 SHALL have ports {a,b}_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports {a,b}_addr  input  DEPTH_LOG  transaction address.
REQ-008 SHALL have ports {a,b}_wdata  input  WIDTH  write data.
REQ-009 SHALL have ports {a,b}_gnt  output  1  registered grant; transfer when req && gnt.
REQ-010 SHALL have ports {a,b}_rdata  output  WIDTH  registered read data.
REQ-011 SHALL have ports {a,b}_rvalid  output  1  one-cycle pulse, rdata valid.
REQ-012 SHALL have port ram_we  output  1  RAM write enable.
REQ-013 SHALL have ports ram_addr_wr / ram_addr_rd  output  DEPTH_LOG  RAM addresses.
REQ-014 SHALL have port ram_data_wr  output  WIDTH  RAM write data.
REQ-015 SHALL have port ram_data_rd  input  WIDTH  RAM asynchronous read data.

Function
REQ-016 FSM states SHALL be IDLE, GNT_A, GNT_B; a_gnt = (state==GNT_A), b_gnt = (state==GNT_B); never both.
REQ-017 Next state SHALL be computed from req at cycle N, effective N+1: none -> IDLE; one -> that client; both -> client not in last_winner.
REQ-018 last_winner (1 bit, A/B) SHALL update only on a transfer, to the transferring client.
REQ-019 A grant cycle without matching req SHALL be a no-op (no RAM write, no rvalid, last_winner unchanged).
REQ-020 In a grant cycle, RAM ports SHALL be muxed combinationally from the grantee; in IDLE, addresses/data = client A's, ram_we = 0.
REQ-021 ram_we SHALL equal transfer && grantee_we && !rst.
REQ-022 Read transfer at cycle N SHALL capture ram_data_rd into grantee's rdata at end of N; rvalid pulses in N+1 (latency 1 from accept).
REQ-023 rdata SHALL hold its value until the next read transfer of that client.
REQ-024 Write at cycle N followed by read of same address at N+1 (either client) SHALL return the new data.
REQ-025 Under continuous requests from both, grants SHALL alternate A,B,A,B (one transfer per cycle sustained).
REQ-026 Single continuous requester SHALL receive gnt every cycle after the first.

Reset
REQ-027 rst SHALL force state IDLE, last_winner = B (A favoured first), all gnt/rvalid = 0, all rdata = 0.
REQ-028 rst asserted during a grant cycle SHALL suppress that write and rvalid; the transaction is lost and the client re-presents it.

Configuration
REQ-029 Macro RAM_ARB_LOCK_EN SHALL, when defined, add inputs a_lock/b_lock (1 bit): while the current grantee has req && lock, next state stays with it regardless of the other requester.
REQ-030 Without RAM_ARB_LOCK_EN the lock ports SHALL not exist and arbitration is pure round-robin per REQ-017.

Verification
REQ-031 Reset, then a_req write addr 2 data 0x5A -> a_gnt cycle 1, ram_we=1, ram_addr_wr=2, ram_data_wr=0x5A.
REQ-032 Both req continuously, A write/B read -> gnt alternates A,B,A,B starting with A; B rvalid 1 cycle after each B accept.
REQ-033 A writes 0x3C to addr 1, B reads addr 1 next cycle -> b_rvalid with b_rdata=0x3C.
REQ-034 rst asserted in A's write grant cycle -> ram_we=0, RAM word unchanged, all outputs reset next cycle.
REQ-035 With RAM_ARB_LOCK_EN, a_lock=1 and both requesting 4 cycles -> 4 consecutive A grants; a_lock=0 -> B granted next.

Source files
------------

// File: rtl/ram_arb_ctrl_if.sv
// Client and RAM side bundle of the two-port RAM arbiter.
// Lock inputs exist only when RAM_ARB_LOCK_EN is defined.
interface ram_arb_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 2
);
    logic                 a_req;
    logic                 a_we;
    logic [DEPTH_LOG-1:0] a_addr;
    logic [WIDTH-1:0]     a_wdata;
    logic                 a_gnt;
    logic [WIDTH-1:0]     a_rdata;
    logic                 a_rvalid;

    logic                 b_req;
    logic                 b_we;
    logic [DEPTH_LOG-1:0] b_addr;
    logic [WIDTH-1:0]     b_wdata;
    logic                 b_gnt;
    logic [WIDTH-1:0]     b_rdata;
    logic                 b_rvalid;

    logic                 ram_we;
    logic [DEPTH_LOG-1:0] ram_addr_wr;
    logic [DEPTH_LOG-1:0] ram_addr_rd;
    logic [WIDTH-1:0]     ram_data_wr;
    logic [WIDTH-1:0]     ram_data_rd;

`ifdef RAM_ARB_LOCK_EN
    logic                 a_lock;
    logic                 b_lock;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_lock,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        input  ram_data_rd,
        output a_gnt, a_rdata, a_rvalid,
        output b_gnt, b_rdata, b_rvalid,
        output ram_we, ram_addr_wr, ram_addr_rd, ram_data_wr
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_lock,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        output ram_data_rd,
        input  a_gnt, a_rdata, a_rvalid,
        input  b_gnt, b_rdata, b_rvalid,
        input  ram_we, ram_addr_wr, ram_addr_rd, ram_data_wr
    );
`else
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_data_rd,
        output a_gnt, a_rdata, a_rvalid,
        output b_gnt, b_rdata, b_rvalid,
        output ram_we, ram_addr_wr, ram_addr_rd, ram_data_wr
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_data_rd,
        input  a_gnt, a_rdata, a_rvalid,
        input  b_gnt, b_rdata, b_rvalid,
        input  ram_we, ram_addr_wr, ram_addr_rd, ram_data_wr
    );
`endif
endinterface

// File: rtl/ram_arb_ctrl.sv
// Round-robin arbiter sharing one async-read RAM between clients A and B.
// Optional grant locking is enabled with the RAM_ARB_LOCK_EN macro.
module ram_arb_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 2
) (
    input  logic          clk,
    input  logic          rst,
    ram_arb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             a_rv_q, a_rv_d;
    logic             b_rv_q, b_rv_d;
    logic [WIDTH-1:0] a_rd_q, a_rd_d;
    logic [WIDTH-1:0] b_rd_q, b_rd_d;

    logic xfer_a, xfer_b;
    logic sel_b, sel_we;
    logic hold_a, hold_b;

    assign xfer_a = (state_q == GNT_A) && bus.a_req;
    assign xfer_b = (state_q == GNT_B) && bus.b_req;
    assign sel_b  = (state_q == GNT_B);
    assign sel_we = sel_b ? bus.b_we : bus.a_we;

    // IDLE and GNT_A both present client A to the RAM
    assign bus.ram_addr_wr = sel_b ? bus.b_addr  : bus.a_addr;
    assign bus.ram_addr_rd = sel_b ? bus.b_addr  : bus.a_addr;
    assign bus.ram_data_wr = sel_b ? bus.b_wdata : bus.a_wdata;
    assign bus.ram_we      = (xfer_a || xfer_b) && sel_we && !rst;

    assign bus.a_gnt    = (state_q == GNT_A);
    assign bus.b_gnt    = (state_q == GNT_B);
    assign bus.a_rvalid = a_rv_q;
    assign bus.b_rvalid = b_rv_q;
    assign bus.a_rdata  = a_rd_q;
    assign bus.b_rdata  = b_rd_q;

`ifdef RAM_ARB_LOCK_EN
    assign hold_a = xfer_a && bus.a_lock;
    assign hold_b = xfer_b && bus.b_lock;
`else
    assign hold_a = 1'b0;
    assign hold_b = 1'b0;
`endif

    always_comb begin
        last_d  = last_q;
        state_d = IDLE;
        if (xfer_a) last_d = 1'b0;
        if (xfer_b) last_d = 1'b1;
        // tie-break uses this cycle's winner so back-to-back grants alternate
        if (hold_a) begin
            state_d = GNT_A;
        end else if (hold_b) begin
            state_d = GNT_B;
        end else if (bus.a_req && bus.b_req) begin
            state_d = last_d ? GNT_A : GNT_B;
        end else if (bus.a_req) begin
            state_d = GNT_A;
        end else if (bus.b_req) begin
            state_d = GNT_B;
        end
    end

    always_comb begin
        a_rv_d = xfer_a && !bus.a_we;
        b_rv_d = xfer_b && !bus.b_we;
        a_rd_d = a_rv_d ? bus.ram_data_rd : a_rd_q;
        b_rd_d = b_rv_d ? bus.ram_data_rd : b_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            a_rd_q  <= a_rd_d;
            b_rd_q  <= b_rd_d;
        end
    end
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Randomized bench for ram_arb_ctrl against a transaction-level model.
// Define RAM_ARB_LOCK_EN to also exercise grant locking.
module tb_ram_arb_ctrl;
    localparam int W  = 8;
    localparam int AL = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arb_ctrl_if #(.WIDTH(W), .DEPTH_LOG(AL)) bus ();

    ram_arb_ctrl #(.WIDTH(W), .DEPTH_LOG(AL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem [D] = '{default: '0};
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr_wr] <= bus.ram_data_wr;
    assign bus.ram_data_rd = mem[bus.ram_addr_rd];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: who owns the upcoming cycle (0 none, 1 A, 2 B) and who is owed
    int           owner;
    bit           b_won_last;
    bit           rv_a, rv_b, xa, xb, acc_a, acc_b;
    logic [W-1:0] rd_a, rd_b;
    logic [W-1:0] ref_mem [D] = '{default: '0};

    task automatic model_reset();
        owner = 0; b_won_last = 1'b1;
        rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;
    endtask

    function automatic int next_owner();
        bit la, lb;
        la = 1'b0; lb = 1'b0;
`ifdef RAM_ARB_LOCK_EN
        la = acc_a && bus.a_lock;
        lb = acc_b && bus.b_lock;
`endif
        if (la) return 1;
        if (lb) return 2;
        if (bus.a_req && bus.b_req) return b_won_last ? 1 : 2;
        if (bus.a_req) return 1;
        if (bus.b_req) return 2;
        return 0;
    endfunction

    task automatic sample();
        @(negedge clk); #1;
        xa = (owner == 1) && bus.a_req;
        xb = (owner == 2) && bus.b_req;
        chk("a_gnt", 32'(bus.a_gnt), 32'(owner == 1));
        chk("b_gnt", 32'(bus.b_gnt), 32'(owner == 2));
        chk("a_rvalid", 32'(bus.a_rvalid), 32'(rv_a));
        chk("b_rvalid", 32'(bus.b_rvalid), 32'(rv_b));
        chk("a_rdata", 32'(bus.a_rdata), 32'(rd_a));
        chk("b_rdata", 32'(bus.b_rdata), 32'(rd_b));
        chk("ram_we", 32'(bus.ram_we),
            32'(((xa && bus.a_we) || (xb && bus.b_we)) && !rst));
        chk("addr_wr", 32'(bus.ram_addr_wr),
            32'(owner == 2 ? bus.b_addr : bus.a_addr));
        chk("addr_rd", 32'(bus.ram_addr_rd),
            32'(owner == 2 ? bus.b_addr : bus.a_addr));
        chk("data_wr", 32'(bus.ram_data_wr),
            32'(owner == 2 ? bus.b_wdata : bus.a_wdata));
    endtask

    task automatic advance();
        acc_a = xa && !rst;
        acc_b = xb && !rst;
        if (rst) begin
            model_reset();
        end else begin
            rv_a = acc_a && !bus.a_we;
            rv_b = acc_b && !bus.b_we;
            if (rv_a) rd_a = ref_mem[bus.a_addr];
            if (rv_b) rd_b = ref_mem[bus.b_addr];
            if (acc_a && bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
            if (acc_b && bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
            if (acc_a) b_won_last = 1'b0;
            if (acc_b) b_won_last = 1'b1;
            owner = next_owner();
        end
        @(posedge clk); #1;
    endtask

    // mode 1: A always writes, B always reads
    task automatic refill(input int pct, input int mode);
        if (acc_a) bus.a_req = 1'b0;
        if (acc_b) bus.b_req = 1'b0;
        if (!bus.a_req && $urandom_range(99) < pct) begin
            bus.a_req   = 1'b1;
            bus.a_we    = (mode == 1) ? 1'b1 : 1'($urandom_range(1));
            bus.a_addr  = AL'($urandom_range(D - 1));
            bus.a_wdata = W'($urandom);
        end
        if (!bus.b_req && $urandom_range(99) < pct) begin
            bus.b_req   = 1'b1;
            bus.b_we    = (mode == 1) ? 1'b0 : 1'($urandom_range(1));
            bus.b_addr  = AL'($urandom_range(D - 1));
            bus.b_wdata = W'($urandom);
        end
    endtask

    task automatic run(input int n, input int pct, input int mode,
                       input int rst_pct);
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(99) < rst_pct);
`ifdef RAM_ARB_LOCK_EN
            bus.a_lock = ($urandom_range(3) == 0);
            bus.b_lock = ($urandom_range(3) == 0);
`endif
            sample();
            advance();
            refill(pct, mode);
        end
        rst = 1'b0;
    endtask

    initial begin
        bit done;
        int na;
        rst = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
        bus.a_lock = 0; bus.b_lock = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        xa = 0; xb = 0; acc_a = 0; acc_b = 0;
        sample();
        advance();
        rst = 1'b0;

        // single write from A: granted the cycle after request
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 2'd2; bus.a_wdata = 8'h5A;
        sample();
        advance();
        sample();
        chk("w1_gnt", 32'(bus.a_gnt), 32'd1);
        chk("w1_we", 32'(bus.ram_we), 32'd1);
        chk("w1_addr", 32'(bus.ram_addr_wr), 32'd2);
        chk("w1_data", 32'(bus.ram_data_wr), 32'h5A);
        advance();
        bus.a_req = 0;
        sample();
        advance();

        // A writes addr 1, B reads it the cycle after
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 2'd1; bus.a_wdata = 8'h3C;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            sample();
            if (xa) begin
                bus.b_req = 1; bus.b_we = 0; bus.b_addr = 2'd1;
                done = 1;
            end
            advance();
        end
        if (!done) chk("raw_a_timeout", 32'd0, 32'd1);
        bus.a_req = 0;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            sample();
            advance();
            if (acc_b) begin
                bus.b_req = 0;
                done = 1;
            end
        end
        if (!done) chk("raw_b_timeout", 32'd0, 32'd1);
        sample();
        chk("raw_rvalid", 32'(bus.b_rvalid), 32'd1);
        chk("raw_rdata", 32'(bus.b_rdata), 32'h3C);
        advance();

        // reset landing on A's write grant cycle kills the write
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 2'd3; bus.a_wdata = 8'hA5;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (owner == 1) begin
                rst = 1'b1;
                done = 1;
            end
            sample();
            if (done) chk("rst_we", 32'(bus.ram_we), 32'd0);
            advance();
            rst = 1'b0;
        end
        if (!done) chk("rst_timeout", 32'd0, 32'd1);
        sample();
        chk("rst_mem", 32'(mem[3]), 32'(ref_mem[3]));
        advance();
        refill(0, 0);
        run(6, 0, 0, 0);

        // both clients saturated: A writes, B reads, grants alternate
        acc_a = 0; acc_b = 0;
        refill(100, 1);
        run(16, 100, 1, 0);

`ifdef RAM_ARB_LOCK_EN
        // A holds the grant while locked, then B is served
        bus.a_lock = 1; bus.b_lock = 0;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (owner == 1) done = 1;
            else begin
                sample();
                advance();
                refill(100, 1);
            end
        end
        if (!done) chk("lock_timeout", 32'd0, 32'd1);
        na = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.a_lock = 0;
            sample();
            if (bus.a_gnt) na++;
            advance();
            refill(100, 1);
        end
        chk("lock_a_run", 32'(na), 32'd4);
        sample();
        chk("lock_b_next", 32'(bus.b_gnt), 32'd1);
        advance();
        refill(100, 1);
`endif

        // randomized traffic with sporadic resets
        run(400, 60, 0, 3);
        run(200, 95, 0, 0);

        for (int i = 0; i < D; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
